// File: rtl/game_pkg.sv
// Shared definitions for the game display blocks: FSM states, clamp limits
// and the active-low 7-segment glyph table (bit6=g .. bit0=a).
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int         SCORE_MAX = 9999;
    localparam int         TIMER_MAX = 99;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/score_timer_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD codes blank.
module seg7_decode
    import game_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_glyph(bcd);

endmodule

// File: rtl/score_timer_display.sv
// Score/timer to six-digit HEX display with a sequential double-dabble converter.
// Optional game-over blink is built only when GAME_OVER_BLINK_EN is defined.
module score_timer_display
    import game_pkg::*;
#(
    parameter int SCORE_W      = 14,
    parameter int TIMER_W      = 6,
    parameter int BLINK_CYCLES = 25_000_000
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic [TIMER_W-1:0] timer,
    input  logic               game_over,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [6:0]         hex5,
    output logic               busy,
    output logic               update
);

    localparam int CNT_W = $clog2(SCORE_W);

    state_t state_reg, state_next;

    logic               dirty_reg;
    logic [SCORE_W-1:0] snap_score_reg;
    logic [TIMER_W-1:0] snap_timer_reg;
    logic [SCORE_W-1:0] score_bin_reg;
    logic [SCORE_W-1:0] timer_bin_reg;
    logic [15:0]        score_bcd_reg;
    logic [7:0]         timer_bcd_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [6:0]         hex_reg [6];
    logic               update_reg;

    logic               start;
    logic [SCORE_W-1:0] score_clamped;
    logic [SCORE_W-1:0] timer_ext;
    logic [SCORE_W-1:0] timer_clamped;
    logic [15:0]        score_adj;
    logic [7:0]         timer_adj;
    logic [3:0]         digit [6];
    logic [6:0]         seg [6];
    logic [6:0]         disp [6];
    logic               blank_all;

    assign start = dirty_reg || ({score, timer} != {snap_score_reg, snap_timer_reg});

    // Clamp works on the snapshot so mid-pass input changes cannot leak in.
    assign score_clamped = (snap_score_reg > SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : snap_score_reg;
    assign timer_ext     = SCORE_W'(snap_timer_reg);
    assign timer_clamped = (timer_ext > SCORE_W'(TIMER_MAX)) ? SCORE_W'(TIMER_MAX) : timer_ext;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_score_lane
            assign score_adj[gi*4 +: 4] = dabble_adj(score_bcd_reg[gi*4 +: 4]);
            assign digit[gi]            = score_bcd_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 2; gi++) begin : g_timer_lane
            assign timer_adj[gi*4 +: 4] = dabble_adj(timer_bcd_reg[gi*4 +: 4]);
            assign digit[gi+4]          = timer_bcd_reg[gi*4 +: 4];
        end
        for (gi = 0; gi < 6; gi++) begin : g_digit
            seg7_decode u_dec (
                .bcd (digit[gi]),
                .seg (seg[gi])
            );
            assign disp[gi] = blank_all ? SEG_BLANK : hex_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_reg      <= 1'b1;
            snap_score_reg <= '0;
            snap_timer_reg <= '0;
            score_bin_reg  <= '0;
            timer_bin_reg  <= '0;
            score_bcd_reg  <= '0;
            timer_bcd_reg  <= '0;
            cnt_reg        <= '0;
            update_reg     <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                hex_reg[i] <= SEG_BLANK;
            end
        end else begin
            update_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        snap_score_reg <= score;
                        snap_timer_reg <= timer;
                        dirty_reg      <= 1'b0;
                    end
                end
                LOAD: begin
                    score_bin_reg <= score_clamped;
                    timer_bin_reg <= timer_clamped;
                    score_bcd_reg <= '0;
                    timer_bcd_reg <= '0;
                    cnt_reg       <= CNT_W'(SCORE_W - 1);
                end
                SHIFT: begin
                    // Both lanes run the same step count; the timer lane's upper bits are zero.
                    {score_bcd_reg, score_bin_reg} <= {score_adj[14:0], score_bin_reg, 1'b0};
                    {timer_bcd_reg, timer_bin_reg} <= {timer_adj[6:0], timer_bin_reg, 1'b0};
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    for (int i = 0; i < 6; i++) begin
                        hex_reg[i] <= seg[i];
                    end
                    update_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GAME_OVER_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES) + 1;

    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_off_reg;

    // The on phase begins with game_over; dropping it restores the display next edge.
    always_ff @(posedge clk) begin
        if (rst || !game_over) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= ~blink_off_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    assign blank_all = blink_off_reg;
`else
    logic unused_blink;

    assign unused_blink = game_over ^ (BLINK_CYCLES == 0);
    assign blank_all    = 1'b0;
`endif

    assign hex0   = disp[0];
    assign hex1   = disp[1];
    assign hex2   = disp[2];
    assign hex3   = disp[3];
    assign hex4   = disp[4];
    assign hex5   = disp[5];
    assign busy   = (state_reg != IDLE);
    assign update = update_reg;

endmodule
